// File: rtl/stack_alu_sequencer_if.sv
// Bundle between the stack ALU sequencer, its host/loader and the stack ALU.
// slave = the sequencer, master = the host/ALU side.
interface stack_alu_sequencer_if #(
  parameter int N  = 8,
  parameter int AW = 4
);
  // Host / loader side
  logic            prog_we;
  logic [AW-1:0]   prog_addr;
  logic [N+2:0]    prog_wdata;
  logic            start;
  logic            busy;
  logic            done;
  logic            err;
  logic [AW-1:0]   err_pc;
  logic [N-1:0]    result_data;
  logic            result_valid;
  logic            ovf_seen;

  // Stack ALU command side
  logic [2:0]      alu_opcode;
  logic [N-1:0]    alu_data;
  logic [N-1:0]    alu_result;
  logic            alu_success;
  logic            alu_overflow;

  modport slave (
    input  prog_we, prog_addr, prog_wdata, start,
    input  alu_result, alu_success, alu_overflow,
    output busy, done, err, err_pc, result_data, result_valid, ovf_seen,
    output alu_opcode, alu_data
  );

  modport master (
    output prog_we, prog_addr, prog_wdata, start,
    output alu_result, alu_success, alu_overflow,
    input  busy, done, err, err_pc, result_data, result_valid, ovf_seen,
    input  alu_opcode, alu_data
  );
endinterface

// File: rtl/stack_alu_sequencer.sv
// Runs a small stored program of stack instructions against a stack ALU,
// one instruction at a time, streaming results and stopping on the first failure.
module stack_alu_sequencer #(
  parameter int N     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stack_alu_sequencer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b011;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SAMPLE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [2:0]    op_q, op_d;
  logic [N-1:0]  operand_q, operand_d;
  logic          err_q, err_d;
  logic [AW-1:0] err_pc_q, err_pc_d;
  logic [N-1:0]  result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic          ovf_q, ovf_d;

  logic [N+2:0]  mem [DEPTH];
  logic [N+2:0]  rd_q;
  logic [2:0]    rd_op;
  logic [N-1:0]  rd_operand;

  assign rd_op      = rd_q[N+2:N];
  assign rd_operand = rd_q[N-1:0];

  // NOTE: program memory carries no reset so it maps onto plain RAM and the
  // loaded program survives rst_n. The read is addressed with pc_d, so the
  // word for the next pc is already registered while FETCH is active.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (state_q == S_IDLE)) begin
      mem[bus.prog_addr] <= bus.prog_wdata;
    end
    rd_q <= mem[pc_d];
  end

  // NOTE: every next-state variable gets its default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    op_d           = op_q;
    operand_d      = operand_q;
    err_d          = err_q;
    err_pc_d       = err_pc_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    ovf_d          = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end

      S_FETCH: begin
        case (rd_op)
          OP_HALT: state_d = S_DONE;
          OP_PUSH, OP_POP, OP_ADD, OP_MUL: begin
            op_d      = rd_op;
            operand_d = rd_operand;
            state_d   = S_ISSUE;
          end
          default: begin
            // Illegal opcode: abort before anything reaches the ALU.
            err_d    = 1'b1;
            err_pc_d = pc_q;
            state_d  = S_DONE;
          end
        endcase
      end

      S_ISSUE: state_d = S_WAIT;

      S_WAIT:  state_d = S_SAMPLE;

      S_SAMPLE: begin
        if (!bus.alu_success) begin
          err_d    = 1'b1;
          err_pc_d = pc_q;
          state_d  = S_DONE;
        end else begin
          if (op_q != OP_PUSH) begin
            result_d       = bus.alu_result;
            result_valid_d = 1'b1;
          end
          if (((op_q == OP_ADD) || (op_q == OP_MUL)) && bus.alu_overflow) begin
            ovf_d = 1'b1;
          end
          if (pc_q == AW'(DEPTH - 1)) begin
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = S_FETCH;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      op_q           <= 3'b000;
      operand_q      <= '0;
      err_q          <= 1'b0;
      err_pc_q       <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      op_q           <= op_d;
      operand_q      <= operand_d;
      err_q          <= err_d;
      err_pc_q       <= err_pc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      ovf_q          <= ovf_d;
    end
  end

  // Outputs are decoded from reset registers, so asserting rst_n drops busy
  // and the ALU command at once without producing a done pulse.
  assign bus.busy         = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                            (state_q == S_WAIT)  || (state_q == S_SAMPLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.err          = err_q;
  assign bus.err_pc       = err_pc_q;
  assign bus.result_data  = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.ovf_seen     = ovf_q;
  assign bus.alu_opcode   = (state_q == S_ISSUE) ? op_q      : 3'b000;
  assign bus.alu_data     = (state_q == S_ISSUE) ? operand_q : '0;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Directed bench for stack_alu_sequencer with a behavioural 8-deep stack ALU.
module tb_stack_alu_sequencer;
  localparam int N     = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int MAX_SIZE = 8;

  localparam logic [2:0] PUSH = 3'b110;
  localparam logic [2:0] POP  = 3'b111;
  localparam logic [2:0] ADD  = 3'b100;
  localparam logic [2:0] MUL  = 3'b101;
  localparam logic [2:0] HALT = 3'b011;

  logic clk = 1'b0;
  logic rst_n;

  stack_alu_sequencer_if #(.N(N), .AW(AW)) bus ();

  stack_alu_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural stack ALU ----------------
  // add/mul read the top two entries without popping; pop returns the top.
  logic [N-1:0] stk [MAX_SIZE];
  int           sp;

  function automatic int alu_calc(input logic [2:0] op, input logic signed [7:0] a,
                                  input logic signed [7:0] b);
    return (op == ADD) ? (int'(a) + int'(b)) : (int'(a) * int'(b));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp               <= 0;
      bus.alu_result   <= '0;
      bus.alu_success  <= 1'b0;
      bus.alu_overflow <= 1'b0;
    end else begin
      case (bus.alu_opcode)
        PUSH: begin
          if (sp < MAX_SIZE) begin
            stk[sp]          <= bus.alu_data;
            sp               <= sp + 1;
            bus.alu_success  <= 1'b1;
            bus.alu_overflow <= 1'b0;
          end else begin
            bus.alu_success  <= 1'b0;
          end
        end
        POP: begin
          if (sp >= 1) begin
            bus.alu_result   <= stk[sp-1];
            sp               <= sp - 1;
            bus.alu_success  <= 1'b1;
            bus.alu_overflow <= 1'b0;
          end else begin
            bus.alu_success  <= 1'b0;
          end
        end
        ADD, MUL: begin
          if (sp >= 2) begin
            bus.alu_result   <= 8'(alu_calc(bus.alu_opcode, stk[sp-1], stk[sp-2]));
            bus.alu_overflow <= (alu_calc(bus.alu_opcode, stk[sp-1], stk[sp-2]) > 127) ||
                                (alu_calc(bus.alu_opcode, stk[sp-1], stk[sp-2]) < -128);
            bus.alu_success  <= 1'b1;
          end else begin
            bus.alu_success  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  typedef struct packed {
    logic [15:0][10:0] prog;
    int                len;
    logic              poke;       // drive prog_we/start mid-run
    logic              exp_err;
    logic [3:0]        exp_err_pc;
    logic              exp_ovf;
    int                exp_nres;
    logic [1:0][7:0]   exp_res;
    int                exp_cycles; // busy-high cycles plus the done cycle
  } vec_t;

  vec_t vecs [5];

  // Per-run observations
  int          cyc;
  int          nres;
  logic [7:0]  res_log [4];
  int          bad_op;
  logic        done_seen;

  function automatic logic [10:0] ins(input logic [2:0] op, input logic [7:0] d);
    return {op, d};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_prog(input int idx);
    for (int i = 0; i < vecs[idx].len; i++) begin
      @(negedge clk);
      bus.prog_we    = 1'b1;
      bus.prog_addr  = AW'(i);
      bus.prog_wdata = vecs[idx].prog[i];
    end
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  task automatic run_prog(input string name, input logic poke);
    cyc = 0; nres = 0; bad_op = 0; done_seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 200 && !done_seen; i++) begin
      @(negedge clk);
      bus.start   = 1'b0;
      bus.prog_we = 1'b0;
      if (bus.busy) cyc++;
      if (bus.result_valid) begin
        if (nres < 4) res_log[nres] = bus.result_data;
        nres++;
      end
      if (bus.alu_opcode inside {3'b001, 3'b010, 3'b011}) bad_op++;
      if (bus.done) begin
        cyc++;
        done_seen = 1'b1;
      end
      if (poke && cyc == 3) begin
        bus.prog_we    = 1'b1;
        bus.prog_addr  = AW'(2);
        bus.prog_wdata = {HALT, 8'h00};
        bus.start      = 1'b1;
      end
    end
    check({name, " done seen"}, 32'(done_seen), 32'd1);
    check({name, " no illegal opcode issued"}, 32'(bad_op), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;

    rst_n          = 1'b0;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_wdata = '0;
    bus.start      = 1'b0;

    // ---- vector table ----
    for (int i = 0; i < 5; i++) vecs[i] = '0;

    vecs[0].prog[0] = ins(PUSH, 8'd5);
    vecs[0].prog[1] = ins(PUSH, 8'd7);
    vecs[0].prog[2] = ins(ADD,  8'd0);
    vecs[0].prog[3] = ins(POP,  8'd0);
    vecs[0].prog[4] = ins(HALT, 8'd0);
    vecs[0].len = 5;  vecs[0].exp_nres = 2;
    vecs[0].exp_res[0] = 8'd12; vecs[0].exp_res[1] = 8'd7;
    vecs[0].exp_cycles = 18;

    vecs[1].prog[0] = ins(PUSH, 8'd100);
    vecs[1].prog[1] = ins(PUSH, 8'd2);
    vecs[1].prog[2] = ins(MUL,  8'd0);
    vecs[1].prog[3] = ins(HALT, 8'd0);
    vecs[1].len = 4;  vecs[1].exp_ovf = 1'b1; vecs[1].exp_nres = 1;
    vecs[1].exp_res[0] = 8'hC8;
    vecs[1].exp_cycles = 14;

    vecs[2].prog[0] = ins(POP, 8'd0);
    vecs[2].len = 1;  vecs[2].exp_err = 1'b1; vecs[2].exp_err_pc = 4'd0;
    vecs[2].exp_cycles = 5;

    vecs[3].prog[0] = ins(PUSH, 8'd1);
    vecs[3].prog[1] = ins(PUSH, 8'd2);
    vecs[3].prog[2] = ins(3'b001, 8'd3);
    vecs[3].len = 3;  vecs[3].poke = 1'b1;
    vecs[3].exp_err = 1'b1; vecs[3].exp_err_pc = 4'd2;
    vecs[3].exp_cycles = 10;

    for (int i = 0; i < 16; i++) vecs[4].prog[i] = ins(PUSH, 8'(i + 1));
    vecs[4].len = 16; vecs[4].exp_err = 1'b1; vecs[4].exp_err_pc = 4'd8;
    vecs[4].exp_cycles = 37;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("reset busy",         32'(bus.busy),         32'd0);
    check("reset done",         32'(bus.done),         32'd0);
    check("reset err",          32'(bus.err),          32'd0);
    check("reset err_pc",       32'(bus.err_pc),       32'd0);
    check("reset result_data",  32'(bus.result_data),  32'd0);
    check("reset result_valid", 32'(bus.result_valid), 32'd0);
    check("reset ovf_seen",     32'(bus.ovf_seen),     32'd0);
    check("reset alu_opcode",   32'(bus.alu_opcode),   32'd0);
    check("reset alu_data",     32'(bus.alu_data),     32'd0);
    rst_n = 1'b1;

    // ---- table-driven programs ----
    for (int i = 0; i < 5; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      do_reset();
      load_prog(i);
      run_prog(nm, vecs[i].poke);
      check({nm, " err"},      32'(bus.err),      32'(vecs[i].exp_err));
      check({nm, " ovf_seen"}, 32'(bus.ovf_seen), 32'(vecs[i].exp_ovf));
      check({nm, " cycles"},   32'(cyc),          32'(vecs[i].exp_cycles));
      check({nm, " results"},  32'(nres),         32'(vecs[i].exp_nres));
      if (vecs[i].exp_err)
        check({nm, " err_pc"}, 32'(bus.err_pc), 32'(vecs[i].exp_err_pc));
      for (int j = 0; j < vecs[i].exp_nres && j < nres; j++)
        check($sformatf("%s result %0d", nm, j), 32'(res_log[j]), 32'(vecs[i].exp_res[j]));
      if (vecs[i].exp_nres > 0)
        check({nm, " result_data hold"}, 32'(bus.result_data),
              32'(vecs[i].exp_res[vecs[i].exp_nres-1]));
      @(negedge clk);
      check({nm, " busy after done"}, 32'(bus.busy), 32'd0);
      check({nm, " done one cycle"},  32'(bus.done), 32'd0);
      if (vecs[i].poke) begin
        // Mid-run write must not have replaced the illegal word at pc 2.
        run_prog({nm, " rerun"}, 1'b0);
        check({nm, " rerun err"},    32'(bus.err),    32'd1);
        check({nm, " rerun err_pc"}, 32'(bus.err_pc), 32'd2);
      end
    end

    // ---- reset during WAIT, then rerun the untouched program ----
    do_reset();
    load_prog(0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);                      // FETCH
    bus.start = 1'b0;
    @(negedge clk);                      // ISSUE
    check("issue opcode", 32'(bus.alu_opcode), 32'(PUSH));
    check("issue data",   32'(bus.alu_data),   32'd5);
    @(negedge clk);                      // WAIT
    check("wait busy",    32'(bus.busy),       32'd1);
    check("wait opcode",  32'(bus.alu_opcode), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst busy",     32'(bus.busy),       32'd0);
    check("rst opcode",   32'(bus.alu_opcode), 32'd0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("rst no done pulse", 32'(dones), 32'd0);
    run_prog("after rst", 1'b0);
    check("after rst err",     32'(bus.err), 32'd0);
    check("after rst cycles",  32'(cyc),     32'd18);
    check("after rst results", 32'(nres),    32'd2);
    check("after rst result 0", 32'(res_log[0]), 32'd12);
    check("after rst result 1", 32'(res_log[1]), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
